// File: rtl/mem_arbiter2_pkg.sv
// rtl/mem_arbiter2_pkg.sv - state encoding, constants and grant helper for the two-master memory arbiter
package mem_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Returns 1 when master 1 should be granted; contention goes to the master that was not served last.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return !last;
    end
    return v1;
  endfunction

endpackage

// File: rtl/mem_arbiter2_if.sv
// rtl/mem_arbiter2_if.sv - valid/ready memory request bus used on both arbiter sides
interface mem_arbiter2_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - round-robin arbiter of two masters onto one shared memory bus
// Optional stall timeout enabled by defining MEM_ARBITER2_TIMEOUT_EN.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_irq
);

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        last_grant_next;
  logic        cur;
  logic        sel_valid;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        timeout_hit;

  assign cur       = (state == GRANT1);
  assign sel_valid = cur ? m1_valid : m0_valid;
  assign sel_addr  = cur ? m1_addr  : m0_addr;
  assign sel_wdata = cur ? m1_wdata : m0_wdata;
  assign sel_wstrb = cur ? m1_wstrb : m0_wstrb;

`ifdef MEM_ARBITER2_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt;

  // Held at zero in IDLE so every grant starts counting from a clean slate.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      stall_cnt <= '0;
    end else if (!s_ready) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Fires the cycle after the count reached TIMEOUT_CYCLES-1; a late s_ready still wins.
  assign timeout_hit = (state != IDLE) && sel_valid && !s_ready && (stall_cnt == TIMEOUT_LIMIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    s_valid         = 1'b0;
    s_addr          = '0;
    s_wdata         = '0;
    s_wstrb         = '0;
    m0_ready        = 1'b0;
    m0_rdata        = '0;
    m1_ready        = 1'b0;
    m1_rdata        = '0;
    timeout_irq     = 1'b0;

    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_next = pick_grant(m0_valid, m1_valid, last_grant) ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        s_valid     = sel_valid && !timeout_hit;
        s_addr      = sel_addr;
        s_wdata     = sel_wdata;
        s_wstrb     = sel_wstrb;
        timeout_irq = timeout_hit;
        if (cur) begin
          m1_ready = s_ready || timeout_hit;
          m1_rdata = timeout_hit ? TIMEOUT_RDATA : s_rdata;
        end else begin
          m0_ready = s_ready || timeout_hit;
          m0_rdata = timeout_hit ? TIMEOUT_RDATA : s_rdata;
        end
        if ((sel_valid && s_ready) || timeout_hit) begin
          state_next      = IDLE;
          last_grant_next = cur;
        end else if (!sel_valid) begin
          // Master withdrew its request: abandon without counting it as served.
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are combinational from state, so mask them while reset is held.
    if (!resetn) begin
      s_valid     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      m0_ready    = 1'b0;
      m0_rdata    = '0;
      m1_ready    = 1'b0;
      m1_rdata    = '0;
      timeout_irq = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - self-checking bench for mem_arbiter2
module tb_mem_arbiter2;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic resetn;
  logic timeout_irq;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter2_if m0_bus();
  mem_arbiter2_if m1_bus();
  mem_arbiter2_if s_bus();

  always #5 clk = ~clk;

  mem_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_bus.valid),
    .m0_addr    (m0_bus.addr),
    .m0_wdata   (m0_bus.wdata),
    .m0_wstrb   (m0_bus.wstrb),
    .m0_ready   (m0_bus.ready),
    .m0_rdata   (m0_bus.rdata),
    .m1_valid   (m1_bus.valid),
    .m1_addr    (m1_bus.addr),
    .m1_wdata   (m1_bus.wdata),
    .m1_wstrb   (m1_bus.wstrb),
    .m1_ready   (m1_bus.ready),
    .m1_rdata   (m1_bus.rdata),
    .s_valid    (s_bus.valid),
    .s_addr     (s_bus.addr),
    .s_wdata    (s_bus.wdata),
    .s_wstrb    (s_bus.wstrb),
    .s_ready    (s_bus.ready),
    .s_rdata    (s_bus.rdata),
    .timeout_irq(timeout_irq)
  );

  function automatic logic [3:0] obs_ctl();
    return {s_bus.valid, m0_bus.ready, m1_bus.ready, timeout_irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_m(input int n, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (n == 0) begin
      m0_bus.valid = v; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wstrb = s;
    end else begin
      m1_bus.valid = v; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wstrb = s;
    end
  endtask

  task automatic set_s(input logic r, input logic [31:0] d);
    s_bus.ready = r;
    s_bus.rdata = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    set_s(1'b0, '0);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_m(0, 1'b1, 32'h10, 32'h11, 4'hF);
    set_m(1, 1'b1, 32'h20, 32'h22, 4'h3);
    set_s(1'b1, 32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      checks++;
      if (obs_ctl() !== 4'b0000) begin
        errors++; $display("FAIL reset_ctl got %b exp 0000", obs_ctl());
      end
      checks++;
      if ({s_bus.addr, s_bus.wdata, s_bus.wstrb, m0_bus.rdata, m1_bus.rdata} !== '0) begin
        errors++; $display("FAIL reset_data got %h/%h/%h/%h/%h exp all 0", s_bus.addr, s_bus.wdata,
                           s_bus.wstrb, m0_bus.rdata, m1_bus.rdata);
      end
    end
    tick();
  endtask

  task automatic test_read();
    do_reset();
    set_m(0, 1'b1, 32'h0000_0010, 32'h0, 4'b0000);
    settle();
    checks++;
    if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL read_arb got %b exp 0000", obs_ctl()); end
    for (int k = 0; k < 2; k++) begin
      tick();
      settle();
      checks++;
      if (obs_ctl() !== 4'b1000 || s_bus.addr !== 32'h10 || s_bus.wstrb !== 4'b0000) begin
        errors++; $display("FAIL read_wait%0d got %b addr %h strb %b exp 1000 addr 10 strb 0", k,
                           obs_ctl(), s_bus.addr, s_bus.wstrb);
      end
    end
    tick();
    set_s(1'b1, 32'h1234_5678);
    settle();
    checks++;
    if (obs_ctl() !== 4'b1100 || m0_bus.rdata !== 32'h1234_5678 || m1_bus.rdata !== 32'h0) begin
      errors++; $display("FAIL read_done got %b rdata %h/%h exp 1100 12345678/0", obs_ctl(),
                         m0_bus.rdata, m1_bus.rdata);
    end
    tick();
    set_m(0, 1'b0, '0, '0, '0);
    set_s(1'b0, '0);
    settle();
    checks++;
    if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL read_after got %b exp 0000", obs_ctl()); end
  endtask

  task automatic test_write();
    do_reset();
    set_m(1, 1'b1, 32'h0300_0000, 32'hCAFE_F00D, 4'b0011);
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1000 || {s_bus.addr, s_bus.wdata, s_bus.wstrb} !== {32'h0300_0000, 32'hCAFE_F00D, 4'b0011}) begin
      errors++; $display("FAIL write_fwd got %b %h %h %b exp 1000 03000000 cafef00d 0011", obs_ctl(),
                         s_bus.addr, s_bus.wdata, s_bus.wstrb);
    end
    tick();
    set_s(1'b1, 32'h0BAD_0001);
    settle();
    checks++;
    if (obs_ctl() !== 4'b1010 || m1_bus.rdata !== 32'h0BAD_0001 || m0_bus.rdata !== 32'h0) begin
      errors++; $display("FAIL write_done got %b rdata %h/%h exp 1010 0/0bad0001", obs_ctl(),
                         m0_bus.rdata, m1_bus.rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int owner;
    do_reset();
    set_m(0, 1'b1, 32'h0000_1000, 32'h1, 4'hF);
    set_m(1, 1'b1, 32'h0000_2000, 32'h2, 4'hF);
    set_s(1'b1, 32'h77);
    for (int k = 0; k < 12; k++) begin
      settle();
      checks++;
      if (k % 2 == 0) begin
        if (obs_ctl() !== 4'b0000) begin
          errors++; $display("FAIL rr_idle k=%0d got %b exp 0000", k, obs_ctl());
        end
      end else begin
        owner = ((k - 1) / 2) % 2;
        if (obs_ctl() !== {1'b1, owner == 0, owner == 1, 1'b0} ||
            s_bus.addr !== (owner == 1 ? 32'h2000 : 32'h1000)) begin
          errors++; $display("FAIL rr_grant k=%0d got %b addr %h exp owner m%0d", k, obs_ctl(),
                             s_bus.addr, owner);
        end
      end
      tick();
    end
  endtask

  task automatic test_protocol_violation();
    do_reset();
    set_m(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    set_s(1'b1, 32'h0);
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1010) begin errors++; $display("FAIL pv_m1 got %b exp 1010", obs_ctl()); end
    tick();
    set_m(1, 1'b0, '0, '0, '0);
    set_m(0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
    set_s(1'b0, '0);
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1000) begin errors++; $display("FAIL pv_m0_grant got %b exp 1000", obs_ctl()); end
    tick();
    set_m(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    settle();
    checks++;
    if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL pv_drop got %b exp 0000", obs_ctl()); end
    tick();
    set_m(0, 1'b1, 32'h0000_1004, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h0000_2004, 32'h0, 4'h0);
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1000 || s_bus.addr !== 32'h0000_1004) begin
      errors++; $display("FAIL pv_last_grant got %b addr %h exp 1000 addr 00001004", obs_ctl(), s_bus.addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_m(0, 1'b1, 32'h0000_0040, 32'h0, 4'h0);
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1000) begin errors++; $display("FAIL rm_grant got %b exp 1000", obs_ctl()); end
    tick();
    settle();
    tick();
    resetn = 1'b0;
    set_s(1'b1, 32'h4444_4444);
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if (obs_ctl() !== 4'b0000 || m0_bus.rdata !== 32'h0) begin
        errors++; $display("FAIL rm_in_reset%0d got %b rdata %h exp 0000 0", k, obs_ctl(), m0_bus.rdata);
      end
      tick();
    end
    resetn = 1'b1;
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b1, 32'h0000_0080, 32'h0, 4'h0);
    settle();
    checks++;
    if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL rm_release got %b exp 0000", obs_ctl()); end
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1010 || s_bus.addr !== 32'h0000_0080 || m1_bus.rdata !== 32'h4444_4444) begin
      errors++; $display("FAIL rm_m1 got %b addr %h rdata %h exp 1010 00000080 44444444", obs_ctl(),
                         s_bus.addr, m1_bus.rdata);
    end
    tick();
  endtask

`ifdef MEM_ARBITER2_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_m(0, 1'b1, 32'h0000_0044, 32'h0, 4'h0);
    settle();
    tick();
    for (int k = 0; k < TO; k++) begin
      settle();
      checks++;
      if (obs_ctl() !== 4'b1000) begin errors++; $display("FAIL to_stall k=%0d got %b exp 1000", k, obs_ctl()); end
      tick();
    end
    settle();
    checks++;
    if (obs_ctl() !== 4'b0101 || m0_bus.rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL to_fire got %b rdata %h exp 0101 deadbeef", obs_ctl(), m0_bus.rdata);
    end
    tick();
    set_m(0, 1'b1, 32'h0000_0048, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    settle();
    checks++;
    if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL to_idle got %b exp 0000", obs_ctl()); end
    tick();
    settle();
    checks++;
    if (obs_ctl() !== 4'b1000 || s_bus.addr !== 32'h0000_2000) begin
      errors++; $display("FAIL to_next_rr got %b addr %h exp 1000 00002000", obs_ctl(), s_bus.addr);
    end
    tick();
  endtask

  task automatic test_ready_race();
    do_reset();
    set_m(0, 1'b1, 32'h0000_0050, 32'h0, 4'h0);
    settle();
    tick();
    for (int k = 0; k < TO; k++) begin
      settle();
      tick();
    end
    set_s(1'b1, 32'hA5A5_0001);
    settle();
    checks++;
    if (obs_ctl() !== 4'b1100 || m0_bus.rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL race got %b rdata %h exp 1100 a5a50001", obs_ctl(), m0_bus.rdata);
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    do_reset();
    set_m(0, 1'b1, 32'h0000_0044, 32'h0, 4'h0);
    settle();
    tick();
    for (int k = 0; k < 3 * TO; k++) begin
      settle();
      checks++;
      if (obs_ctl() !== 4'b1000) begin errors++; $display("FAIL nto_stall k=%0d got %b exp 1000", k, obs_ctl()); end
      tick();
    end
    set_s(1'b1, 32'h0000_0C0C);
    settle();
    checks++;
    if (obs_ctl() !== 4'b1100 || m0_bus.rdata !== 32'h0000_0C0C) begin
      errors++; $display("FAIL nto_done got %b rdata %h exp 1100 00000c0c", obs_ctl(), m0_bus.rdata);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic        req_v[2];
    logic [31:0] req_a[2];
    logic [31:0] req_d[2];
    logic [3:0]  req_s[2];
    logic        done[2];
    logic        sr;
    logic [31:0] sd;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    int          owner;
    int          last;
    int          lat;
    int          waited;
    do_reset();
    owner  = -1;
    last   = 1;
    lat    = 0;
    waited = 0;
    for (int n = 0; n < 2; n++) begin
      req_v[n] = 1'b0; req_a[n] = '0; req_d[n] = '0; req_s[n] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      sr = (waited >= lat);
      sd = $urandom;
      for (int n = 0; n < 2; n++) set_m(n, req_v[n], req_a[n], req_d[n], req_s[n]);
      set_s(sr, sd);
      settle();
      if (owner < 0) begin
        exp_ctl = 4'b0000;
        exp_r0  = '0;
        exp_r1  = '0;
      end else begin
        exp_ctl = {req_v[owner], (owner == 0) && sr, (owner == 1) && sr, 1'b0};
        exp_r0  = (owner == 0) ? sd : 32'h0;
        exp_r1  = (owner == 1) ? sd : 32'h0;
      end
      checks++;
      if (obs_ctl() !== exp_ctl || m0_bus.rdata !== exp_r0 || m1_bus.rdata !== exp_r1) begin
        errors++; $display("FAIL rand_ctl cyc=%0d got %b %h/%h exp %b %h/%h", cyc, obs_ctl(),
                           m0_bus.rdata, m1_bus.rdata, exp_ctl, exp_r0, exp_r1);
      end
      if (owner >= 0) begin
        checks++;
        if ({s_bus.addr, s_bus.wdata, s_bus.wstrb} !== {req_a[owner], req_d[owner], req_s[owner]}) begin
          errors++; $display("FAIL rand_fwd cyc=%0d got %h %h %b exp m%0d %h %h %b", cyc, s_bus.addr,
                             s_bus.wdata, s_bus.wstrb, owner, req_a[owner], req_d[owner], req_s[owner]);
        end
      end
      done[0] = 1'b0;
      done[1] = 1'b0;
      if (owner < 0) begin
        if (req_v[0] || req_v[1]) owner = (req_v[0] && req_v[1]) ? 1 - last : (req_v[1] ? 1 : 0);
      end else if (req_v[owner] && sr) begin
        done[owner] = 1'b1;
        last   = owner;
        owner  = -1;
        waited = 0;
        lat    = $urandom_range(0, 4);
      end else begin
        waited++;
      end
      tick();
      for (int n = 0; n < 2; n++) begin
        if (done[n] || !req_v[n]) begin
          req_v[n] = done[n] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
          req_a[n] = $urandom;
          req_d[n] = $urandom;
          req_s[n] = 4'($urandom_range(0, 15));
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    set_s(1'b0, '0);
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_protocol_violation();
    test_reset_mid();
    test_timeout();
`ifdef MEM_ARBITER2_TIMEOUT_EN
    test_ready_race();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
